// File: rtl/multiport_latency_ram_if.sv
// Memory request bus shared by all ports of multiport_latency_ram.
// Every per-port field is packed into a flat vector.
// Port p occupies slice [p*W +: W] of each vector.
//   mem_read    master -> slave  per-port read request
//   mem_write   master -> slave  per-port write request
//   mem_addr    master -> slave  per-port word address
//   mem_data_w  master -> slave  per-port write data
//   mem_data_r  slave  -> master per-port registered read data
//   mem_wait    slave  -> master per-port stall (request not yet acknowledged)
interface multiport_latency_ram_if #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32
);
  logic [N_PORTS-1:0]        mem_read;
  logic [N_PORTS-1:0]        mem_write;
  logic [N_PORTS*ADDR_W-1:0] mem_addr;
  logic [N_PORTS*DATA_W-1:0] mem_data_w;
  logic [N_PORTS*DATA_W-1:0] mem_data_r;
  logic [N_PORTS-1:0]        mem_wait;

  modport master (
    output mem_read, mem_write, mem_addr, mem_data_w,
    input  mem_data_r, mem_wait
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_data_w,
    output mem_data_r, mem_wait
  );
endinterface

// File: rtl/multiport_latency_ram.sv
// Behavioural shared backing memory for multicore simulation.
// N_PORTS masters contend through a round-robin arbiter, and one access is in flight at a time.
// A read waits READ_LAT extra cycles and a write waits WRITE_LAT extra cycles.
// A combined read+write waits the larger of the two and is write-first.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (memory contents are kept)
//   en   clock enable; when low, all state holds
//   bus  slave side of multiport_latency_ram_if (requests in, read data and mem_wait out)
module multiport_latency_ram #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int SIZE      = 2**ADDR_W,
  parameter int N_PORTS   = 2,
  parameter int READ_LAT  = 3,
  parameter int WRITE_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  multiport_latency_ram_if.slave  bus
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  // cnt holds at most MAX_LAT-1
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int PORT_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [PORT_W-1:0] grant;
  logic [PORT_W-1:0] last;
  logic [PORT_W-1:0] pick;
  logic [PORT_W-1:0] idx_p;
  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] ack;
  logic              any_req;
  logic              start;
  logic              perform;

  // request captured when the access is granted
  logic              lat_rd;
  logic              lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  // picked port's live request, used when the grant happens this cycle
  logic              pick_rd;
  logic              pick_wr;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;
  int                pick_lat;

  // the access performed on this edge, when perform is high
  logic [PORT_W-1:0] acc_port;
  logic              acc_rd;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] rd_value;

  logic [DATA_W-1:0] mem [SIZE] = '{default: '0};

  function automatic int access_lat(input logic rd, input logic wr);
    int l;
    if (rd && wr) begin
      l = MAX_LAT;
    end else if (rd) begin
      l = READ_LAT;
    end else begin
      l = WRITE_LAT;
    end
    return l;
  endfunction

  // Addresses at or above SIZE exist only when SIZE < 2**ADDR_W.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(SIZE));
  endfunction

  assign req          = bus.mem_read | bus.mem_write;
  assign any_req      = |req;
  assign bus.mem_wait = req & ~ack;

  // Decode the one-cycle acknowledge for the granted port.
  always_comb begin
    ack = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      ack[p] = (state == DONE) && (grant == PORT_W'(p));
    end
  end

  // Round-robin search starting after the last grant.
  // The loop runs from the farthest port to the nearest, so the nearest requester wins.
  always_comb begin
    pick  = last;
    idx_p = '0;
    for (int i = N_PORTS; i >= 1; i--) begin
      idx_p = PORT_W'((int'(last) + i) % N_PORTS);
      pick  = req[idx_p] ? idx_p : pick;
    end
  end

  // Pick out the chosen port's fields and the latency they imply.
  always_comb begin
    pick_rd    = bus.mem_read[pick];
    pick_wr    = bus.mem_write[pick];
    pick_addr  = bus.mem_addr[int'(pick)*ADDR_W +: ADDR_W];
    pick_wdata = bus.mem_data_w[int'(pick)*DATA_W +: DATA_W];
    pick_lat   = access_lat(pick_rd, pick_wr);
  end

  // FSM next-state logic: countdown in BUSY, single ack cycle in DONE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    perform   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          start = 1'b1;
          if (pick_lat == 0) begin
            perform   = 1'b1;
            state_nxt = DONE;
          end else begin
            cnt_nxt   = CNT_W'(pick_lat - 1);
            state_nxt = BUSY;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          perform   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Select the access: live inputs for a zero-latency grant in IDLE, otherwise the captured request.
  always_comb begin
    if (state == IDLE) begin
      acc_port  = pick;
      acc_rd    = pick_rd;
      acc_wr    = pick_wr;
      acc_addr  = pick_addr;
      acc_wdata = pick_wdata;
    end else begin
      acc_port  = grant;
      acc_rd    = lat_rd;
      acc_wr    = lat_wr;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
    end
  end

  // Compute the read return value.
  // A combined read+write returns the new write data, and an out-of-range address returns zero.
  always_comb begin
    if (!addr_ok(acc_addr)) begin
      rd_value = '0;
    end else if (acc_wr) begin
      rd_value = acc_wdata;
    end else begin
      rd_value = mem[acc_addr];
    end
  end

  // FSM state, countdown, grant and round-robin pointer.
  // Reset makes port 0 win the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      grant <= '0;
      last  <= PORT_W'(N_PORTS - 1);
    end else if (en) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (start) begin
        grant <= pick;
        last  <= pick;
      end
    end
  end

  // Capture the granted request so that a master withdrawing early cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (en && start) begin
      lat_rd    <= pick_rd;
      lat_wr    <= pick_wr;
      lat_addr  <= pick_addr;
      lat_wdata <= pick_wdata;
    end
  end

  // Storage write.
  // The array is never cleared, and a reset edge abandons a write that is still pending.
  always_ff @(posedge clk) begin
    if (!rst && en && perform && acc_wr && addr_ok(acc_addr)) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

  // Per-port read data register; only the reading port's word changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_data_r <= '0;
    end else if (en && perform && acc_rd) begin
      bus.mem_data_r[int'(acc_port)*DATA_W +: DATA_W] <= rd_value;
    end
  end

endmodule
